// File: rtl/ysyx_24090018_pc_unit.sv
// ysyx_24090018_pc_unit
// Program-counter unit for the JX500 multi-cycle core. It offers the current PC
// to the IFU through a valid/ready handshake. It then waits for the commit stage
// to report a sequential advance, a redirect or a trap. It also counts retired
// (non-trap) instructions.
//
// Optional feature macro: YSYX_24090018_PC_ALIGN_CHECK_EN
//   When this macro is defined, a redirect target that is not a multiple of
//   INST_BYTES is turned into a trap entry (pc <- trap_vec_i). In that case
//   misalign_o pulses and misalign_pc_o captures the bad target. When the macro
//   is undefined, targets are taken as-is and both misalign outputs stay 0.
module ysyx_24090018_pc_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 32'h8000_0000,
  parameter int                    INST_BYTES = 4,
  parameter int                    CNT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic                  pc_valid_o,
  input  logic                  ifu_ready_i,
  input  logic                  commit_valid_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
  input  logic                  trap_i,
  input  logic [ADDR_WIDTH-1:0] trap_vec_i,
  output logic [CNT_WIDTH-1:0]  retire_cnt_o,
  output logic                  misalign_o,
  output logic [ADDR_WIDTH-1:0] misalign_pc_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INST_BYTES);
  localparam logic [CNT_WIDTH-1:0]  CNT_STEP = CNT_WIDTH'(1);

  state_e                state_r;
  state_e                state_nxt_s;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] pc_nxt_s;
  logic                  pc_valid_r;
  logic                  pc_valid_nxt_s;
  logic [CNT_WIDTH-1:0]  retire_cnt_r;
  logic [CNT_WIDTH-1:0]  retire_cnt_nxt_s;
  logic                  misalign_r;
  logic                  misalign_nxt_s;
  logic [ADDR_WIDTH-1:0] misalign_pc_r;
  logic [ADDR_WIDTH-1:0] misalign_pc_nxt_s;
  logic                  bad_target_s;

`ifdef YSYX_24090018_PC_ALIGN_CHECK_EN
  // INST_BYTES is a power of two, so the low bits give the remainder.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(INST_BYTES - 1);

  // Returns 1 when addr is not a whole multiple of INST_BYTES.
  function automatic logic is_misaligned(input logic [ADDR_WIDTH-1:0] addr);
    return |(addr & ALIGN_MASK);
  endfunction

  assign bad_target_s = is_misaligned(redirect_pc_i);
`else
  assign bad_target_s = 1'b0;
`endif

  // FSM state register; reset always returns to BOOT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= BOOT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and next-output logic; holding everything is the default.
  always_comb begin
    state_nxt_s       = state_r;
    pc_nxt_s          = pc_r;
    pc_valid_nxt_s    = pc_valid_r;
    retire_cnt_nxt_s  = retire_cnt_r;
    misalign_nxt_s    = 1'b0;
    misalign_pc_nxt_s = misalign_pc_r;
    case (state_r)
      BOOT: begin
        state_nxt_s    = REQ;
        pc_valid_nxt_s = 1'b1;
      end
      REQ: begin
        // A stray commit while offering is ignored.
        if (ifu_ready_i) begin
          state_nxt_s    = WAIT;
          pc_valid_nxt_s = 1'b0;
        end else begin
          state_nxt_s    = REQ;
          pc_valid_nxt_s = 1'b1;
        end
      end
      WAIT: begin
        if (commit_valid_i) begin
          state_nxt_s    = REQ;
          pc_valid_nxt_s = 1'b1;
          if (trap_i) begin
            pc_nxt_s = trap_vec_i;
          end else if (redirect_i && bad_target_s) begin
            // A bad target becomes a trap and does not retire.
            pc_nxt_s          = trap_vec_i;
            misalign_nxt_s    = 1'b1;
            misalign_pc_nxt_s = redirect_pc_i;
          end else if (redirect_i) begin
            pc_nxt_s         = redirect_pc_i;
            retire_cnt_nxt_s = retire_cnt_r + CNT_STEP;
          end else begin
            pc_nxt_s         = pc_r + PC_STEP;
            retire_cnt_nxt_s = retire_cnt_r + CNT_STEP;
          end
        end else begin
          state_nxt_s    = WAIT;
          pc_valid_nxt_s = 1'b0;
        end
      end
      default: begin
        state_nxt_s    = BOOT;
        pc_valid_nxt_s = 1'b0;
      end
    endcase
  end

  // Output registers: every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= RESET_ADDR;
      pc_valid_r    <= 1'b0;
      retire_cnt_r  <= '0;
      misalign_r    <= 1'b0;
      misalign_pc_r <= '0;
    end else begin
      pc_r          <= pc_nxt_s;
      pc_valid_r    <= pc_valid_nxt_s;
      retire_cnt_r  <= retire_cnt_nxt_s;
      misalign_r    <= misalign_nxt_s;
      misalign_pc_r <= misalign_pc_nxt_s;
    end
  end

  assign pc_o          = pc_r;
  assign pc_valid_o    = pc_valid_r;
  assign retire_cnt_o  = retire_cnt_r;
  assign misalign_o    = misalign_r;
  assign misalign_pc_o = misalign_pc_r;

endmodule
